led_step_sequencer: RTL

- Controller that sequences the 4-bit LED pattern register on a prescaled time base.
- Replaces the free-running LED counter with a start/pause/stop-controlled run of a programmable number of steps, in one of four pattern modes.
- Sits between board buttons/switches (already synchronised upstream) and the LED pins.
- Exposes busy/done status for a VIO probe or a higher-level test controller.

---
 rtl/led_step_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/led_step_sequencer.sv
// Start/pause/stop controlled LED pattern sequencer on a prescaled time base.
// Runs a programmable number of steps in one of four pattern modes.
module led_step_sequencer #(
    parameter int unsigned DIV = 100000000,
    parameter int unsigned CW  = 32
) (
    input  logic       w_clk,
    input  logic       w_rst_n,
    input  logic       w_start,
    input  logic       w_stop,
    input  logic       w_pause,
    input  logic [1:0] w_mode,
    input  logic [3:0] w_len,
    output logic [3:0] w_led,
    output logic       w_busy,
    output logic       w_done,
    output logic       w_tick
);

    // state | meaning
    // IDLE  | waiting for start; LEDs show last final pattern or 0000
    // RUN   | prescaler counting, pattern advances on each tick
    // PAUSE | prescaler, step count and pattern frozen
    // DONE  | one cycle after the final step, then back to IDLE
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    localparam logic [CW-1:0] PRESC_MAX = CW'(DIV - 1);

    state_t        state, state_nx;
    logic [CW-1:0] presc, presc_nx;
    logic [4:0]    step, step_nx;
    logic [4:0]    len_q, len_nx;
    logic [1:0]    mode_q, mode_nx;
    logic [3:0]    led_q, led_nx;
    logic          busy_nx, done_nx, tick_nx;
    logic          tick_now, last_step;

    function automatic logic [3:0] init_pat(input logic [1:0] m);
        case (m)
            2'd1:    return 4'b1111;
            2'd2:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] advance(input logic [1:0] m, input logic [3:0] p);
        case (m)
            2'd0:    return p + 4'd1;
            2'd1:    return p - 4'd1;
            2'd2:    return {p[2:0], p[3]};
            default: return ~p;
        endcase
    endfunction

    assign tick_now  = (state == S_RUN) && (presc == PRESC_MAX);
    assign last_step = tick_now && ((step + 5'd1) == len_q);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (!w_stop && w_start) state_nx = S_RUN;
            S_RUN: begin
                if (w_stop)         state_nx = S_IDLE;
                else if (last_step) state_nx = S_DONE;
                else if (w_pause)   state_nx = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_stop)         state_nx = S_IDLE;
                else if (!w_pause)  state_nx = S_RUN;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        presc_nx = presc;
        step_nx  = step;
        len_nx   = len_q;
        mode_nx  = mode_q;
        led_nx   = led_q;
        if (w_stop) begin
            // abort from any state: blank LEDs and clear counters
            presc_nx = '0;
            step_nx  = '0;
            led_nx   = 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (w_start) begin
                        mode_nx  = w_mode;
                        len_nx   = (w_len == 4'd0) ? 5'd16 : {1'b0, w_len};
                        led_nx   = init_pat(w_mode);
                        presc_nx = '0;
                        step_nx  = '0;
                    end
                end
                S_RUN: begin
                    if (tick_now) begin
                        presc_nx = '0;
                        step_nx  = step + 5'd1;
                        led_nx   = advance(mode_q, led_q);
                    end else begin
                        presc_nx = presc + CW'(1);
                    end
                end
                default: ;
            endcase
        end
        tick_nx = tick_now && !w_stop;
        done_nx = (state == S_DONE) && !w_stop;
        busy_nx = (state_nx == S_RUN) || (state_nx == S_PAUSE);
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            presc  <= '0;
            step   <= '0;
            len_q  <= 5'd16;
            mode_q <= 2'd0;
            led_q  <= 4'b0000;
            w_busy <= 1'b0;
            w_done <= 1'b0;
            w_tick <= 1'b0;
        end else begin
            presc  <= presc_nx;
            step   <= step_nx;
            len_q  <= len_nx;
            mode_q <= mode_nx;
            led_q  <= led_nx;
            w_busy <= busy_nx;
            w_done <= done_nx;
            w_tick <= tick_nx;
        end
    end

    assign w_led = led_q;

endmodule
